sqrt_iter_ctrl: RTL and testbench
=================================

# sqrt_iter_ctrl

Sequential square-root engine for the SqrtBinary datapath family. It computes floor(sqrt(p)) and the remainder of a SIZE-bit unsigned operand. It uses the modified non-restoring recurrence, producing one root bit per clock. The controller sequences the iterations and wraps the computation in valid/ready handshakes on both sides, so the block can sit on a pipeline bus in place of the wide combinational SqrtBinary array.

## Interface
- SIZE, 16, operand width; must be even.
- HALF_SIZE, 8, root width; must equal SIZE/2.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand p is valid.
- in_ready  output  1  block accepts an operand this cycle.
- p  input  SIZE  unsigned radicand.
- out_valid  output  1  root/rem hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- u  output  HALF_SIZE  floor(sqrt(p)).
- rem  output  HALF_SIZE+1  p - u*u, range 0..2u.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. When in_valid=1 on an edge:
  - Capture p into the operand register.
  - Clear the root register q (HALF_SIZE bits) and the signed remainder r (HALF_SIZE+2 bits).
  - Load the iteration counter with HALF_SIZE-1.
  - Go to CALC.
- CALC performs one iteration per edge, for i = counter, counting down to 0:
  - Form t = (r<<2) | operand[2i+1:2i].
  - If r >= 0: r <= t - ((q<<2) | 2'b01).
  - Otherwise: r <= t + ((q<<2) | 2'b11).
  - Shift in the new root bit: q <= (q<<1) | (new r >= 0).
  - At counter 0, go to FIX. Otherwise decrement the counter.
- FIX (one edge):
  - If r < 0: r <= r + ((q<<1) | 1).
  - Load u <= q and rem <= r[HALF_SIZE:0].
  - Set out_valid and go to DONE.
- DONE:
  - out_valid=1. u and rem stay stable until out_valid=1 and out_ready=1 on the same edge.
  - On that handshake: clear out_valid, go to IDLE.
- Input rules:
  - in_ready=0 outside IDLE. in_valid outside IDLE is ignored and not queued.
  - p is sampled only on the accept edge; later changes have no effect on the running operation.
- Arithmetic:
  - All r add/subtract operations are two's complement in HALF_SIZE+2 bits and never overflow for legal SIZE.
  - rem never exceeds 2*(2^HALF_SIZE - 1), so it fits in HALF_SIZE+1 bits.
- Reset:
  - rst_n low forces IDLE immediately, regardless of clk, and aborts any operation in flight; the result is discarded.
  - Reset values: in_ready=0 while rst_n=0, then 1 in IDLE. out_valid=0, busy=0, u=0, rem=0, q=0, r=0, counter=0.

## Timing
- Accept edge T (in_valid and in_ready both 1).
- CALC covers edges T+1 through T+HALF_SIZE.
- FIX runs on edge T+HALF_SIZE+1. out_valid rises after this edge, so latency is HALF_SIZE+1 cycles (9 at defaults).
- A handshake on the first DONE cycle returns the block to IDLE one edge later. in_ready is high in the following cycle.
- Minimum accept-to-accept interval is HALF_SIZE+3 cycles (11 at defaults).
- Backpressure: each cycle of out_ready=0 in DONE adds one cycle.
- busy is high from edge T until the output-handshake edge, inclusive.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Test plan
- Known values, one operand at a time with out_ready=1:
  - p=0 -> u=0, rem=0.
  - p=144 -> u=12, rem=0.
  - p=143 -> u=11, rem=22.
  - p=65535 -> u=255, rem=510.
  - Each with out_valid exactly 9 cycles after the accept edge.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises.
  - Required: u and rem stay stable and in_ready stays 0.
  - Required: release gives a single handshake, then in_ready=1 on the next cycle.
- Busy rejection: drive in_valid=1 with p=9 throughout CALC of p=400.
  - Required: result u=20, rem=0.
  - Required: p=9 is accepted only once the block is back in IDLE, then completes with u=3, rem=0.
- Async reset mid-CALC: assert rst_n=0 at iteration 4 of p=1000, between clock edges.
  - Required: out_valid, busy, u and rem go to 0 immediately.
  - Required: the next operand p=1000 after reset gives u=31, rem=39.
- Randomized: 100 $random operands with random out_ready.
  - Required: u*u <= p < (u+1)^2 and rem == p - u*u for every result.
  - Required: no result lost or duplicated.
- Parameter sweep: SIZE=4/HALF_SIZE=2 and SIZE=32/HALF_SIZE=16.
  - Required: p=15 -> u=3, rem=6.
  - Required: p=4294967295 -> u=65535, rem=131070.
  - Required: latency equals HALF_SIZE+1.

Source files
------------

// File: rtl/sqrt_iter_ctrl.sv
// Sequential integer square root: one root bit per clock, non-restoring
// recurrence, with valid/ready handshakes on the operand and result sides.
module sqrt_iter_ctrl #(
    parameter int SIZE      = 16,
    parameter int HALF_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIZE-1:0]      p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [HALF_SIZE-1:0] u,
    output logic [HALF_SIZE:0]   rem,
    output logic                 busy
);

    localparam int RW = HALF_SIZE + 2;
    localparam int CW = (HALF_SIZE > 1) ? $clog2(HALF_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SIZE-1:0]        opnd_q, opnd_d;
    logic [HALF_SIZE-1:0]   q_q, q_d;
    logic [RW-1:0]          r_q, r_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [HALF_SIZE-1:0]   u_q, u_d;
    logic [HALF_SIZE:0]     rem_q, rem_d;
    logic                   ov_q, ov_d;

    logic [1:0]             digit;
    logic [RW-1:0]          t;
    logic [RW-1:0]          r_step;
    logic [RW-1:0]          r_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            u_q     <= '0;
            rem_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            u_q     <= u_d;
            rem_q   <= rem_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        u_d     = u_q;
        rem_d   = rem_q;
        ov_d    = ov_q;

        digit = opnd_q[{cnt_q, 1'b0} +: 2];
        t     = {r_q[HALF_SIZE-1:0], digit};
        // Sign of the partial remainder picks subtract or add-back.
        if (!r_q[RW-1]) begin
            r_step = t - {q_q, 2'b01};
        end else begin
            r_step = t + {q_q, 2'b11};
        end
        if (r_q[RW-1]) begin
            r_fix = r_q + {1'b0, q_q, 1'b1};
        end else begin
            r_fix = r_q;
        end

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opnd_d  = p;
                    q_d     = '0;
                    r_d     = '0;
                    cnt_d   = CW'(HALF_SIZE - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                r_d = r_step;
                q_d = {q_q[HALF_SIZE-2:0], ~r_step[RW-1]};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                r_d     = r_fix;
                u_d     = q_q;
                rem_d   = r_fix[HALF_SIZE:0];
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = rst_n & (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = ov_q;
    assign u         = u_q;
    assign rem       = rem_q;

endmodule

// File: tb/tb_sqrt_iter_ctrl.sv
// Directed and randomized checks of sqrt_iter_ctrl at three sizes
// against an arithmetic integer-square-root model.
module tb_sqrt_iter_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] p;
    logic [7:0]  u;
    logic [8:0]  rem;

    logic        iv4, ir4, ov4, or4, busy4;
    logic [3:0]  p4;
    logic [1:0]  u4;
    logic [2:0]  rem4;

    logic        iv32, ir32, ov32, or32, busy32;
    logic [31:0] p32;
    logic [15:0] u32;
    logic [16:0] rem32;

    int compared = 0;
    int mismatched = 0;

    sqrt_iter_ctrl #(.SIZE(16), .HALF_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .p(p),
        .out_valid(out_valid), .out_ready(out_ready),
        .u(u), .rem(rem), .busy(busy)
    );

    sqrt_iter_ctrl #(.SIZE(4), .HALF_SIZE(2)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .p(p4),
        .out_valid(ov4), .out_ready(or4),
        .u(u4), .rem(rem4), .busy(busy4)
    );

    sqrt_iter_ctrl #(.SIZE(32), .HALF_SIZE(16)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32), .p(p32),
        .out_valid(ov32), .out_ready(or32),
        .u(u32), .rem(rem32), .busy(busy32)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint isqrt(input longint v);
        longint r = 0;
        for (int b = 16; b >= 0; b--) begin
            longint c = r | (longint'(1) << b);
            if (c * c <= v) r = c;
        end
        return r;
    endfunction

    task automatic wait_ov(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_one(input logic [15:0] pv, input int eu, input int er);
        int n;
        @(negedge clk);
        check("idle_ready", in_ready, 1);
        in_valid = 1'b1;
        p = pv;
        @(negedge clk);
        in_valid = 1'b0;
        p = 16'($urandom);
        check("busy_calc", busy, 1);
        wait_ov(n);
        check("latency", n, 9);
        check("u", u, eu);
        check("rem", rem, er);
        @(negedge clk);
        check("ov_drop", out_valid, 0);
        check("ready_back", in_ready, 1);
        check("busy_drop", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, hs;
        logic [15:0] pv;
        logic [7:0]  gu;
        logic [8:0]  gr;
        logic        done;
        longint      eu;

        rst_n = 1'b0;
        in_valid = 1'b0; p = '0; out_ready = 1'b1;
        iv4 = 1'b0; p4 = '0; or4 = 1'b1;
        iv32 = 1'b0; p32 = '0; or32 = 1'b1;
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_ov", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_u", u, 0);
        check("rst_rem", rem, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_one(16'd0, 0, 0);
        run_one(16'd144, 12, 0);
        run_one(16'd143, 11, 22);
        run_one(16'd65535, 255, 510);

        // backpressure
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; p = 16'd143;
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov(n);
        check("bp_latency", n, 9);
        repeat (5) begin
            check("bp_u", u, 11);
            check("bp_rem", rem, 22);
            check("bp_ready", in_ready, 0);
            check("bp_ov", out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ov_drop", out_valid, 0);
        check("bp_ready_back", in_ready, 1);

        // busy rejection
        in_valid = 1'b1; p = 16'd400;
        @(negedge clk);
        p = 16'd9;
        check("rej_ready", in_ready, 0);
        wait_ov(n);
        check("rej_lat", n, 9);
        check("rej_u", u, 20);
        check("rej_rem", rem, 0);
        @(negedge clk);
        check("rej_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_ov(n);
        check("rej2_lat", n, 9);
        check("rej2_u", u, 3);
        check("rej2_rem", rem, 0);
        @(negedge clk);

        // async reset mid-calculation
        in_valid = 1'b1; p = 16'd1000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_ov", out_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_u", u, 0);
        check("ar_rem", rem, 0);
        check("ar_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(16'd1000, 31, 39);

        // randomized with random backpressure
        hs = 0;
        for (int k = 0; k < 100; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pv = 16'($urandom);
            check("rnd_ready", in_ready, 1);
            in_valid = 1'b1; p = pv;
            @(negedge clk);
            in_valid = 1'b0;
            n = 0; done = 1'b0;
            while (!done && n < 200) begin
                @(negedge clk);
                n++;
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    gu = u; gr = rem;
                    @(negedge clk);
                    check("rnd_nodup", out_valid, 0);
                    hs++;
                    done = 1'b1;
                end
            end
            check("rnd_done", done, 1);
            eu = isqrt(longint'(pv));
            check("rnd_u", gu, eu);
            check("rnd_rem", gr, longint'(pv) - eu * eu);
        end
        out_ready = 1'b1;
        check("rnd_count", hs, 100);

        // small size
        @(negedge clk);
        iv4 = 1'b1; p4 = 4'd15;
        @(negedge clk);
        iv4 = 1'b0;
        n = 0;
        while (ov4 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("s4_lat", n, 3);
        check("s4_u", u4, 3);
        check("s4_rem", rem4, 6);
        @(negedge clk);
        check("s4_ready", ir4, 1);

        // large size
        iv32 = 1'b1; p32 = 32'hFFFF_FFFF;
        @(negedge clk);
        iv32 = 1'b0;
        n = 0;
        while (ov32 !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("s32_lat", n, 17);
        check("s32_u", u32, 65535);
        check("s32_rem", rem32, 131070);
        @(negedge clk);
        check("s32_ready", ir32, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
